// File: rtl/ma_pkg.sv
// Shared definitions for the MA pipeline stage: opcode/funct3 codes, FSM states,
// and the decode and load-extension helpers used by ma_stage_pipe.
package ma_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {IDLE, WAIT} ma_state_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] op2;
    } ex_fields_t;

    // sz: 0 = byte, 1 = half, 2 = word
    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [1:0] sz;
    } mem_dec_t;

    function automatic mem_dec_t ma_decode(input logic [31:0] ins);
        mem_dec_t d;
        d = '0;
        if (ins[6:0] == OPC_LOAD) begin
            case (ins[14:12])
                F3_B, F3_BU: begin d.is_load = 1'b1; d.sz = 2'd0; end
                F3_H, F3_HU: begin d.is_load = 1'b1; d.sz = 2'd1; end
                F3_W:        begin d.is_load = 1'b1; d.sz = 2'd2; end
                default:     d = '0;
            endcase
        end else if (ins[6:0] == OPC_STORE) begin
            case (ins[14:12])
                F3_B:    begin d.is_store = 1'b1; d.sz = 2'd0; end
                F3_H:    begin d.is_store = 1'b1; d.sz = 2'd1; end
                F3_W:    begin d.is_store = 1'b1; d.sz = 2'd2; end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    function automatic logic [31:0] ld_extend(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{raw[7]}}, raw[7:0]};
            F3_H:    r = {{16{raw[15]}}, raw[15:0]};
            F3_W:    r = raw;
            F3_BU:   r = {24'd0, raw[7:0]};
            F3_HU:   r = {16'd0, raw[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bytes.sv
// Byte-addressed data memory with four independent byte lanes: combinational
// read, synchronous write.
module dmem_bytes #(
    parameter int    DMEM_BYTES = 1024,
    parameter string INIT_FILE  = "d_mem.hex",
    parameter int    AW         = $clog2(DMEM_BYTES)
) (
    input  logic                clk2,
    input  logic [3:0]          we_i,
    input  logic [3:0][AW-1:0]  addr_i,
    input  logic [3:0][7:0]     wdata_i,
    output logic [3:0][7:0]     rdata_o
);

    logic [7:0] mem_q [DMEM_BYTES];

    // Lane addresses are always distinct (consecutive modulo a size >= 4).
    always_ff @(posedge clk2) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) mem_q[addr_i[k]] <= wdata_i[k];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_rd
        assign rdata_o[gi] = mem_q[addr_i[gi]];
    end

endmodule

// File: rtl/ma_stage_pipe.sv
// Memory-access pipeline stage: byte/half/word loads and stores with MEM_LAT-cycle
// latency and busy/stall handshakes. Define MA_MISALIGN_TRAP_EN to trap misaligned accesses.
module ma_stage_pipe
    import ma_pkg::*;
#(
    parameter int    DMEM_BYTES = 1024,
    parameter int    MEM_LAT    = 2,
    parameter string INIT_FILE  = "d_mem.hex"
) (
    input  logic        clk2,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluresult,
    input  logic [31:0] ex_instruction,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_op2,
    output logic        ma_busy,
    output logic        ma_valid,
    output logic [31:0] ma_ldresult,
    output logic [31:0] ma_aluresult,
    output logic [31:0] ma_instruction,
    output logic [31:0] ma_pc
`ifdef MA_MISALIGN_TRAP_EN
    ,
    output logic        ma_misalign
`endif
);

    localparam int            AW       = $clog2(DMEM_BYTES);
    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
    localparam bit            SINGLE   = (MEM_LAT == 1);

    ma_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    ex_fields_t         hold_q, cur;
    logic               valid_q, valid_d, busy_q, busy_d, misal_q, misal_d;
    logic [31:0]        ldres_q, ldres_d, alu_q, alu_d, ins_q, ins_d, pc_q, pc_d;
    mem_dec_t           dec;
    logic               accept, complete, misal, unused_bits;
    logic [3:0]         lane_en, we;
    logic [3:0][AW-1:0] lane_addr;
    logic [3:0][7:0]    lane_wdata, lane_rdata;

    assign accept = ex_valid & ~busy_q & ~stall_in & ~rst;

    // In IDLE the instruction is taken straight from EX; in WAIT from the holding register.
    always_comb begin
        cur = hold_q;
        if (state_q == IDLE) begin
            cur = '{ins: ex_instruction, alu: ex_aluresult, pc: ex_pc, op2: ex_op2};
        end
    end

    assign dec = ma_decode(cur.ins);

`ifdef MA_MISALIGN_TRAP_EN
    assign misal = (dec.is_load | dec.is_store) &
                   (((dec.sz == 2'd1) & cur.alu[0]) | ((dec.sz == 2'd2) & (cur.alu[1:0] != 2'b00)));
`else
    assign misal = 1'b0;
`endif

    assign complete = (state_q == IDLE)
                    ? (accept & (~(dec.is_load | dec.is_store) | SINGLE | misal))
                    : ((cnt_q == '0) & ~stall_in & ~rst);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_en[gi]    = (gi == 0) || ((gi == 1) && (dec.sz != 2'd0)) || (dec.sz == 2'd2);
        assign lane_addr[gi]  = cur.alu[AW-1:0] + AW'(gi);
        assign lane_wdata[gi] = cur.op2[8*gi +: 8];
        assign we[gi]         = complete & dec.is_store & ~misal & lane_en[gi];
    end

    dmem_bytes #(
        .DMEM_BYTES (DMEM_BYTES),
        .INIT_FILE  (INIT_FILE),
        .AW         (AW)
    ) u_dmem (
        .clk2    (clk2),
        .we_i    (we),
        .addr_i  (lane_addr),
        .wdata_i (lane_wdata),
        .rdata_o (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        misal_d = misal_q;
        ldres_d = ldres_q;
        alu_d   = alu_q;
        ins_d   = ins_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (accept && !complete) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                // The countdown keeps running under stall; stall only defers completion.
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                if (complete) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
        if (complete) begin
            valid_d = 1'b1;
            misal_d = misal;
            ldres_d = (dec.is_load && !misal) ? ld_extend(lane_rdata, cur.ins[14:12]) : 32'd0;
            alu_d   = cur.alu;
            ins_d   = cur.ins;
            pc_d    = cur.pc;
        end else if (!stall_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            misal_q <= 1'b0;
            ldres_q <= '0;
            alu_q   <= '0;
            ins_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) hold_q <= cur;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            misal_q <= misal_d;
            ldres_q <= ldres_d;
            alu_q   <= alu_d;
            ins_q   <= ins_d;
            pc_q    <= pc_d;
        end
    end

    assign ma_busy        = busy_q;
    assign ma_valid       = valid_q;
    assign ma_ldresult    = ldres_q;
    assign ma_aluresult   = alu_q;
    assign ma_instruction = ins_q;
    assign ma_pc          = pc_q;

`ifdef MA_MISALIGN_TRAP_EN
    assign ma_misalign = misal_q;
    assign unused_bits = ^cur.alu[31:AW];
`else
    assign unused_bits = ^{cur.alu[31:AW], misal_q};
`endif

endmodule

// File: tb/tb_ma_stage_pipe.sv
// Directed self-checking bench for ma_stage_pipe (DMEM_BYTES=1024, MEM_LAT=2).
// Covers both builds of the MA_MISALIGN_TRAP_EN option.
module tb_ma_stage_pipe;
    import ma_pkg::*;

    logic        clk2 = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_aluresult = '0, ex_instruction = '0, ex_pc = '0, ex_op2 = '0;
    logic        ma_busy, ma_valid;
    logic [31:0] ma_ldresult, ma_aluresult, ma_instruction, ma_pc;
`ifdef MA_MISALIGN_TRAP_EN
    logic        ma_misalign;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk2 = ~clk2;

    ma_stage_pipe #(
        .DMEM_BYTES (1024),
        .MEM_LAT    (2),
        .INIT_FILE  ("")
    ) dut (
        .clk2           (clk2),
        .rst            (rst),
        .stall_in       (stall_in),
        .ex_valid       (ex_valid),
        .ex_aluresult   (ex_aluresult),
        .ex_instruction (ex_instruction),
        .ex_pc          (ex_pc),
        .ex_op2         (ex_op2),
        .ma_busy        (ma_busy),
        .ma_valid       (ma_valid),
        .ma_ldresult    (ma_ldresult),
        .ma_aluresult   (ma_aluresult),
        .ma_instruction (ma_instruction),
        .ma_pc          (ma_pc)
`ifdef MA_MISALIGN_TRAP_EN
        ,
        .ma_misalign    (ma_misalign)
`endif
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %08h required %08h", tag, obs, req);
    endtask

    // Present one instruction at a negedge; returns at the negedge after its acceptance edge.
    task automatic drive(input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] op2, input logic [31:0] pc);
        ex_valid = 1'b1; ex_instruction = ins; ex_aluresult = alu; ex_op2 = op2; ex_pc = pc;
        @(negedge clk2);
        ex_valid = 1'b0;
    endtask

    // Multi-cycle memory op: busy for MEM_LAT cycles, valid MEM_LAT cycles after acceptance.
    task automatic run_mem(input string tag, input logic [31:0] ins,
                           input logic [31:0] alu, input logic [31:0] op2);
        drive(ins, alu, op2, 32'h200);
        chk({tag, "_busy_c1"}, 32'(ma_busy), 32'd1);
        chk({tag, "_valid_c1"}, 32'(ma_valid), 32'd0);
        @(negedge clk2);
        chk({tag, "_busy_c2"}, 32'(ma_busy), 32'd1);
        chk({tag, "_valid_c2"}, 32'(ma_valid), 32'd0);
        @(negedge clk2);
        chk({tag, "_valid_done"}, 32'(ma_valid), 32'd1);
        chk({tag, "_busy_done"}, 32'(ma_busy), 32'd0);
        $display("txn %s addr=%08h ldresult=%08h", tag, alu, ma_ldresult);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk2);
        chk("rst_valid", 32'(ma_valid), 32'd0);
        chk("rst_busy", 32'(ma_busy), 32'd0);
        chk("rst_ldres", ma_ldresult, 32'd0);
        chk("rst_alu", ma_aluresult, 32'd0);
        chk("rst_ins", ma_instruction, 32'd0);
        chk("rst_pc", ma_pc, 32'd0);
`ifdef MA_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(ma_misalign), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk2);

        // Pass-through ADD: one-cycle latency, no busy
        drive(mk(7'b0110011, 3'd0), 32'h1234, 32'h0, 32'h100);
        $display("txn add alu=%08h", ma_aluresult);
        chk("add_valid", 32'(ma_valid), 32'd1);
        chk("add_busy", 32'(ma_busy), 32'd0);
        chk("add_alu", ma_aluresult, 32'h1234);
        chk("add_ldres", ma_ldresult, 32'd0);
        chk("add_pc", ma_pc, 32'h100);
        chk("add_ins", ma_instruction, mk(7'b0110011, 3'd0));
        @(negedge clk2);
        chk("add_valid_drop", 32'(ma_valid), 32'd0);

        // Word store then immediately following word load
        run_mem("sw10", mk(OPC_STORE, F3_W), 32'h10, 32'hDEADBEEF);
        chk("sw10_ldres", ma_ldresult, 32'd0);
        chk("sw10_alu", ma_aluresult, 32'h10);
        run_mem("lw10", mk(OPC_LOAD, F3_W), 32'h10, 32'h0);
        chk("lw10_ldres", ma_ldresult, 32'hDEADBEEF);

        // Byte/half extension
        run_mem("sb20", mk(OPC_STORE, F3_B), 32'h20, 32'h0000_0080);
        run_mem("sh80", mk(OPC_STORE, F3_H), 32'h80, 32'h0000_8F80);
        run_mem("lb20", mk(OPC_LOAD, F3_B), 32'h20, 32'h0);
        chk("lb20_ldres", ma_ldresult, 32'hFFFFFF80);
        run_mem("lbu20", mk(OPC_LOAD, F3_BU), 32'h20, 32'h0);
        chk("lbu20_ldres", ma_ldresult, 32'h00000080);
        run_mem("lh80", mk(OPC_LOAD, F3_H), 32'h80, 32'h0);
        chk("lh80_ldres", ma_ldresult, 32'hFFFF8F80);
        run_mem("lhu80", mk(OPC_LOAD, F3_HU), 32'h80, 32'h0);
        chk("lhu80_ldres", ma_ldresult, 32'h00008F80);

        // Downstream stall held three cycles once the countdown has reached zero
        drive(mk(OPC_STORE, F3_W), 32'h40, 32'h11223344, 32'h300);
        chk("stl_busy_c1", 32'(ma_busy), 32'd1);
        @(negedge clk2);
        stall_in = 1'b1;
        repeat (3) begin
            @(negedge clk2);
            chk("stl_valid_hold", 32'(ma_valid), 32'd0);
            chk("stl_busy_hold", 32'(ma_busy), 32'd1);
            chk("stl_ldres_hold", ma_ldresult, 32'h00008F80);
            chk("stl_alu_hold", ma_aluresult, 32'h80);
        end
        stall_in = 1'b0;
        @(negedge clk2);
        $display("txn sw40_stalled alu=%08h", ma_aluresult);
        chk("stl_valid_done", 32'(ma_valid), 32'd1);
        chk("stl_busy_done", 32'(ma_busy), 32'd0);
        chk("stl_alu_done", ma_aluresult, 32'h40);
        stall_in = 1'b1;
        @(negedge clk2);
        chk("stl_valid_kept", 32'(ma_valid), 32'd1);
        stall_in = 1'b0;
        @(negedge clk2);
        chk("stl_valid_drop", 32'(ma_valid), 32'd0);
        run_mem("lw40", mk(OPC_LOAD, F3_W), 32'h40, 32'h0);
        chk("lw40_ldres", ma_ldresult, 32'h11223344);

`ifdef MA_MISALIGN_TRAP_EN
        // Misaligned accesses trap in one cycle without touching memory
        run_mem("sw3fc", mk(OPC_STORE, F3_W), 32'h3FC, 32'h55667788);
        drive(mk(OPC_LOAD, F3_W), 32'h3FE, 32'h0, 32'h400);
        $display("txn lw3fe_misaligned ldresult=%08h", ma_ldresult);
        chk("mis_lw_valid", 32'(ma_valid), 32'd1);
        chk("mis_lw_flag", 32'(ma_misalign), 32'd1);
        chk("mis_lw_ldres", ma_ldresult, 32'd0);
        chk("mis_lw_busy", 32'(ma_busy), 32'd0);
        drive(mk(OPC_STORE, F3_W), 32'h3FE, 32'hFFFFFFFF, 32'h404);
        $display("txn sw3fe_misaligned");
        chk("mis_sw_flag", 32'(ma_misalign), 32'd1);
        run_mem("lw3fc", mk(OPC_LOAD, F3_W), 32'h3FC, 32'h0);
        chk("lw3fc_ldres", ma_ldresult, 32'h55667788);
        chk("mis_flag_clear", 32'(ma_misalign), 32'd0);
`else
        // Misaligned word wraps bytewise around the end of memory
        run_mem("sw3fe", mk(OPC_STORE, F3_W), 32'h3FE, 32'h44332211);
        run_mem("lw3fe", mk(OPC_LOAD, F3_W), 32'h3FE, 32'h0);
        chk("lw3fe_ldres", ma_ldresult, 32'h44332211);
        run_mem("lbu000", mk(OPC_LOAD, F3_BU), 32'h000, 32'h0);
        chk("lbu000_ldres", ma_ldresult, 32'h00000033);
        run_mem("lbu3ff", mk(OPC_LOAD, F3_BU), 32'h3FF, 32'h0);
        chk("lbu3ff_ldres", ma_ldresult, 32'h00000022);
        run_mem("lbu401", mk(OPC_LOAD, F3_BU), 32'h401, 32'h0);
        chk("lbu401_ldres", ma_ldresult, 32'h00000044);
`endif

        // Reset in the middle of a multi-cycle store
        drive(mk(OPC_STORE, F3_W), 32'h10, 32'hCAFEF00D, 32'h500);
        chk("rw_busy_before", 32'(ma_busy), 32'd1);
        rst = 1'b1;
        #1;
        $display("txn sw10_aborted_by_reset");
        chk("rw_valid", 32'(ma_valid), 32'd0);
        chk("rw_busy", 32'(ma_busy), 32'd0);
        chk("rw_ldres", ma_ldresult, 32'd0);
        chk("rw_alu", ma_aluresult, 32'd0);
        chk("rw_ins", ma_instruction, 32'd0);
        chk("rw_pc", ma_pc, 32'd0);
        @(negedge clk2);
        @(negedge clk2);
        rst = 1'b0;
        @(negedge clk2);
        chk("rw_idle_busy", 32'(ma_busy), 32'd0);
        run_mem("lw10_after_rst", mk(OPC_LOAD, F3_W), 32'h10, 32'h0);
        chk("rw_word_kept", ma_ldresult, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
